// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data requester. A single access is in flight at a time;
// each access ends with a one-cycle done pulse to the granted requester,
// either on mem_ready or with err set after TIMEOUT_CYCLES wait cycles.
//
// Optional feature macro: MEM_PORT_ARB_RR_EN
//   defined   -> simultaneous requests alternate using a last-grant pointer
//   undefined -> simultaneous requests always go to the data requester
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,

    output logic                  if_done,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Wait counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [CW-1:0] wait_cnt;
    logic [CW:0]   wait_cnt_inc;
    logic          serving_d;   // granted requester of the current access

    logic          pick_d;      // arbitration result, meaningful in IDLE
    logic          start;       // IDLE -> BUSY_x this cycle
    logic          finish_ok;   // BUSY_x -> DONE on mem_ready
    logic          finish_to;   // BUSY_x -> DONE on timeout
    logic          busy;

    assign busy         = (state == BUSY_IF) || (state == BUSY_D);
    assign wait_cnt_inc = {1'b0, wait_cnt} + 1'b1;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_d;   // 1: most recent grant went to data, 0: to fetch

    // Last-grant pointer, updated on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (start) begin
            last_d <= pick_d;
        end
    end

    // On a tie, the requester not granted last wins.
    always_comb begin
        pick_d = d_req && (!if_req || !last_d);
    end
`else
    // Data requester always wins a tie.
    always_comb begin
        pick_d = d_req;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    start     = 1'b1;
                    state_nxt = pick_d ? BUSY_D : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready) begin
                    finish_ok = 1'b1;
                    state_nxt = DONE;
                end else if (wait_cnt_inc == (CW + 1)'(TIMEOUT_CYCLES)) begin
                    finish_to = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory-port request is a pure decode of the registered state.
    always_comb begin
        mem_req = busy;
        if_done = (state == DONE) && !serving_d;
        d_done  = (state == DONE) && serving_d;
    end

    // Access registers: captured on grant, held for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            serving_d <= 1'b0;
        end else if (start) begin
            serving_d <= pick_d;
            mem_we    <= pick_d && d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
        end
    end

    // Wait counter: cleared on grant, counts cycles without mem_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= '0;
        end else if (busy && !mem_ready) begin
            wait_cnt <= wait_cnt_inc[CW-1:0];
        end
    end

    // Completion result: read data on success, zero on writes and timeouts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (finish_ok) begin
            rdata <= mem_we ? '0 : mem_rdata;
            err   <= 1'b0;
        end else if (finish_to) begin
            rdata <= '0;
            err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_done;
    logic          d_done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .if_done  (if_done),
        .d_done   (d_done),
        .rdata    (rdata),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until a done pulse (or the limit), counting mem_req cycles.
    task automatic wait_done(input int limit, output int cycles, output int req_cycles,
                             output logic saw_d, output logic saw_if);
        cycles     = 0;
        req_cycles = 0;
        do begin
            tick;
            cycles++;
            if (mem_req) req_cycles++;
        end while (cycles < limit && !(if_done || d_done));
        saw_d  = d_done;
        saw_if = if_done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick; tick;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, rdata, err, if_done, d_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h rdata=%h err=%b ifd=%b dd=%b, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, rdata, err, if_done, d_done);
        end
        rst = 1'b0;
        tick;
        total++;
        if ({mem_req, if_done, d_done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_no_req: req=%b ifd=%b dd=%b, want 000", mem_req, if_done, d_done);
        end
    endtask

    task automatic test_fetch;
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        total++;
        if ({mem_req, mem_we, mem_addr, if_done} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
            bad++;
            $display("FAIL fetch_issue: req=%b we=%b addr=%h ifd=%b, want 1 0 00000100 0",
                     mem_req, mem_we, mem_addr, if_done);
        end
        tick;
        total++;
        if ({if_done, d_done, rdata, err, mem_req} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fetch_done: ifd=%b dd=%b rdata=%h err=%b req=%b, want 1 0 deadbeef 0 0",
                     if_done, d_done, rdata, err, mem_req);
        end
        if_req = 1'b0;
        tick;
        total++;
        if ({if_done, mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_single_pulse: ifd=%b req=%b, want 00", if_done, mem_req);
        end
    endtask

    task automatic test_write;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'h55}) begin
            bad++;
            $display("FAIL write_issue: req=%b we=%b addr=%h wdata=%h, want 1 1 00000200 00000055",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick;
        total++;
        if ({d_done, if_done, rdata, err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL write_done: dd=%b ifd=%b rdata=%h err=%b, want 1 0 00000000 0",
                     d_done, if_done, rdata, err);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick;
    endtask

    task automatic test_data_read;
        int cyc, rc;
        logic sd, si;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        wait_done(10, cyc, rc, sd, si);
        total++;
        if ({sd, si, rdata, err, mem_we, mem_addr} !== {1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h300}
            || cyc != 2 || rc != 1) begin
            bad++;
            $display("FAIL data_read: dd=%b ifd=%b rdata=%h err=%b we=%b addr=%h cyc=%0d reqcyc=%0d, want 1 0 cafef00d 0 0 00000300 2 1",
                     sd, si, rdata, err, mem_we, mem_addr, cyc, rc);
        end
        d_req = 1'b0;
        tick;
    endtask

    // Tie after reset goes to data in both modes; fetch is served once data drops.
    task automatic test_priority;
        int cyc, rc;
        logic sd, si;
        rst = 1'b1; tick; rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        mem_ready = 1'b1; mem_rdata = 32'hA1A1A1A1;
        tick;
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
            bad++;
            $display("FAIL tie_first_grant: req=%b addr=%h, want 1 00000500", mem_req, mem_addr);
        end
        tick;
        total++;
        if ({d_done, if_done, rdata} !== {1'b1, 1'b0, 32'hA1A1A1A1}) begin
            bad++;
            $display("FAIL tie_data_done: dd=%b ifd=%b rdata=%h, want 1 0 a1a1a1a1", d_done, if_done, rdata);
        end
        d_req = 1'b0; mem_rdata = 32'hB2B2B2B2;
        wait_done(10, cyc, rc, sd, si);
        total++;
        if ({si, sd, rdata, mem_addr} !== {1'b1, 1'b0, 32'hB2B2B2B2, 32'h400} || cyc != 3) begin
            bad++;
            $display("FAIL tie_fetch_second: ifd=%b dd=%b rdata=%h addr=%h cyc=%0d, want 1 0 b2b2b2b2 00000400 3",
                     si, sd, rdata, mem_addr, cyc);
        end
        if_req = 1'b0;
        tick;
    endtask

    // Both requests held continuously across several grants.
    task automatic test_back_to_back;
        int cyc, rc;
        logic sd, si;
        logic exp_d;
        rst = 1'b1; tick; rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h600; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h680;
        mem_ready = 1'b1; mem_rdata = 32'h0F0F0F0F;
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_PORT_ARB_RR_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            wait_done(10, cyc, rc, sd, si);
            total++;
            if ({sd, si} !== {exp_d, !exp_d} || rc != 1) begin
                bad++;
                $display("FAIL grant_seq[%0d]: dd=%b ifd=%b reqcyc=%0d, want dd=%b ifd=%b reqcyc=1",
                         g, sd, si, rc, exp_d, !exp_d);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int cyc, rc;
        logic sd, si;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
        wait_done(40, cyc, rc, sd, si);
        total++;
        if ({sd, si, err, rdata, mem_req} !== {1'b1, 1'b0, 1'b1, 32'h0, 1'b0} || rc != 15 || cyc != 16) begin
            bad++;
            $display("FAIL timeout: dd=%b ifd=%b err=%b rdata=%h req=%b reqcyc=%0d cyc=%0d, want 1 0 1 00000000 0 15 16",
                     sd, si, err, rdata, mem_req, rc, cyc);
        end
        d_req = 1'b0;
        tick;
        total++;
        if ({d_done, mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_release: dd=%b req=%b, want 00", d_done, mem_req);
        end
    endtask

    task automatic test_reset_mid_access;
        int cyc, rc;
        logic sd, si;
        logic saw_done;
        if_req = 1'b1; if_addr = 32'h700; mem_ready = 1'b0;
        tick; tick; tick;   // BUSY_IF entered, then two wait cycles
        #2 rst = 1'b1;
        #1;
        total++;
        if ({mem_req, if_done, err, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_abort: req=%b ifd=%b err=%b rdata=%h, want all 0", mem_req, if_done, err, rdata);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (if_done || d_done) saw_done = 1'b1;
        end
        rst = 1'b0;
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done: saw_done=%b, want 0", saw_done);
        end
        wait_done(40, cyc, rc, sd, si);
        total++;
        if ({si, sd, err, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h700} || rc != 15 || cyc != 16) begin
            bad++;
            $display("FAIL reset_fresh_access: ifd=%b dd=%b err=%b addr=%h reqcyc=%0d cyc=%0d, want 1 0 1 00000700 15 16",
                     si, sd, err, mem_addr, rc, cyc);
        end
        if_req = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_write;
        test_data_read;
        test_priority;
        test_back_to_back;
        test_timeout;
        test_reset_mid_access;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
